// File: rtl/mmu_translate.sv
// mmu_translate: virtual-to-physical translation FSM with exception classification.
// Optional single-entry micro-TLB enabled by defining MMU_MICRO_TLB_EN.
module mmu_translate #(
  parameter int ENTRY_ADDR_WIDTH = 3
) (
  input  logic        clk,
  input  logic        res,
  input  logic        req,
  input  logic        isWrite,
  input  logic        userMode,
  input  logic [31:0] vAddr,
  input  logic [7:0]  asid,
  output logic        ready,
  output logic        valid,
  output logic        exc,
  output logic [31:0] pAddr,
  output logic [31:0] badVAddr,
  output logic [4:0]  excCode,
  output logic [31:0] tlbVAddr,
  input  logic [31:0] tlbPAddr,
  input  logic        tlbFound,
  input  logic        tlbD,
  input  logic        tlbV,
  input  logic        tlbFlush
);
  localparam int unused_entry_w = ENTRY_ADDR_WIDTH;
  typedef enum logic [1:0] {IDLE, LOOKUP, RESP} state_t;
  state_t state, nxt;
  logic [31:0] va_q, t_pa, hit_pa;
  logic        wr_q, accept, hit, addr_err, unmapped, t_exc;
  logic [4:0]  t_code;

  assign ready    = state == IDLE;
  assign accept   = req & ready;
  assign tlbVAddr = va_q;

  // Address error outranks everything; TLB checks only apply to mapped segments.
  always_comb begin
    addr_err = userMode & va_q[31];
    unmapped = va_q[31:30] == 2'b10;
    t_code   = addr_err ? (wr_q ? 5'd5 : 5'd4) :
               unmapped ? 5'd0 :
               (!tlbFound || !tlbV) ? (wr_q ? 5'd3 : 5'd2) :
               (wr_q && !tlbD) ? 5'd1 : 5'd0;
    t_exc    = t_code != 5'd0;
    t_pa     = t_exc ? 32'd0 : unmapped ? {3'b000, va_q[28:0]} : tlbPAddr;
  end

  always_comb begin
    nxt = state == IDLE   ? (accept ? (hit ? RESP : LOOKUP) : IDLE) :
          state == LOOKUP ? RESP : IDLE;
  end

  always_ff @(posedge clk or posedge res) begin
    if (res) state <= IDLE;
    else     state <= nxt;
  end

  always_ff @(posedge clk or posedge res) begin
    if (res) begin
      valid    <= 1'b0;
      exc      <= 1'b0;
      excCode  <= 5'd0;
      pAddr    <= 32'd0;
      badVAddr <= 32'd0;
      va_q     <= 32'd0;
      wr_q     <= 1'b0;
    end else begin
      valid <= nxt == RESP;
      if (accept) begin
        va_q <= vAddr;
        wr_q <= isWrite;
      end
      if (state == LOOKUP) begin
        pAddr   <= t_pa;
        exc     <= t_exc;
        excCode <= t_code;
        if (t_exc) badVAddr <= va_q;
      end else if (accept && hit) begin
        pAddr   <= hit_pa;
        exc     <= 1'b0;
        excCode <= 5'd0;
      end
    end
  end

`ifdef MMU_MICRO_TLB_EN
  logic [27:0] u_tag;
  logic [19:0] u_pfn;
  logic [7:0]  asid_q;
  logic        u_d, u_v, inval;

  // Any flush or ASID switch invalidates the entry and also blocks a same-cycle hit.
  assign inval  = tlbFlush | (asid != asid_q);
  assign hit    = u_v & !inval & (u_tag == {vAddr[31:12], asid}) & (!isWrite | u_d) &
                  !(userMode & vAddr[31]);
  assign hit_pa = {u_pfn, vAddr[11:0]};

  always_ff @(posedge clk or posedge res) begin
    if (res) begin
      u_v    <= 1'b0;
      u_d    <= 1'b0;
      u_tag  <= 28'd0;
      u_pfn  <= 20'd0;
      asid_q <= 8'd0;
    end else begin
      asid_q <= asid;
      if (inval) u_v <= 1'b0;
      else if (state == LOOKUP && !unmapped && !t_exc) begin
        u_v   <= 1'b1;
        u_tag <= {va_q[31:12], asid};
        u_pfn <= tlbPAddr[31:12];
        u_d   <= tlbD;
      end
    end
  end
`else
  logic unused_utlb;
  assign unused_utlb = ^{tlbFlush, asid};
  assign hit         = 1'b0;
  assign hit_pa      = 32'd0;
`endif
endmodule

// File: tb/tb_mmu_translate.sv
// tb_mmu_translate: directed and randomized checks of mmu_translate against a reference model.
module tb_mmu_translate;
  logic        clk = 0, res = 1, req = 0, isWrite = 0, userMode = 0;
  logic [31:0] vAddr = 0, tlbPAddr = 0;
  logic [7:0]  asid = 0;
  logic        tlbFound = 0, tlbD = 0, tlbV = 0, tlbFlush = 0;
  logic        ready, valid, exc;
  logic [31:0] pAddr, badVAddr, tlbVAddr;
  logic [4:0]  excCode;
  int tests = 0, fails = 0;

`ifdef MMU_MICRO_TLB_EN
  localparam bit UTLB = 1'b1;
`else
  localparam bit UTLB = 1'b0;
`endif

  // reference state: last bad address and the single cached translation
  logic [31:0] bad_exp = 0;
  logic        m_ok = 0, m_d = 0;
  logic [19:0] m_vpn = 0, m_pfn = 0;
  logic [7:0]  m_asid = 0;

  mmu_translate dut (
    .clk(clk), .res(res), .req(req), .isWrite(isWrite), .userMode(userMode),
    .vAddr(vAddr), .asid(asid), .ready(ready), .valid(valid), .exc(exc),
    .pAddr(pAddr), .badVAddr(badVAddr), .excCode(excCode), .tlbVAddr(tlbVAddr),
    .tlbPAddr(tlbPAddr), .tlbFound(tlbFound), .tlbD(tlbD), .tlbV(tlbV), .tlbFlush(tlbFlush)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    tests++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  function automatic void ref_xlate(input logic [31:0] va, input logic wr, user, found, v, d,
                                    input logic [31:0] tpa, output logic e,
                                    output logic [4:0] c, output logic [31:0] pa);
    if (user && va[31])          c = wr ? 5 : 4;
    else if (va[31:30] == 2'b10) c = 0;
    else if (!found || !v)       c = wr ? 3 : 2;
    else if (wr && !d)           c = 1;
    else                         c = 0;
    e  = c != 0;
    pa = e ? 32'd0 : (va[31:30] == 2'b10) ? (va & 32'h1FFF_FFFF) : tpa;
  endfunction

  task automatic do_req(input logic [31:0] va, input logic wr, user, found, v, d,
                        input logic [31:0] tpa);
    logic e, h;
    logic [4:0] c;
    logic [31:0] pa;
    int lat;
    h = UTLB && m_ok && m_vpn == va[31:12] && m_asid == asid && (!wr || m_d) && !(user && va[31]);
    if (h) begin
      e = 0; c = 0; pa = {m_pfn, va[11:0]};
    end else ref_xlate(va, wr, user, found, v, d, tpa, e, c, pa);
    @(negedge clk);
    chk("ready_idle", ready, 1);
    vAddr = va; isWrite = wr; userMode = user;
    tlbFound = found; tlbV = v; tlbD = d; tlbPAddr = tpa; req = 1;
    @(negedge clk);
    req = 0; vAddr = $urandom; isWrite = 1'($urandom);
    lat = 1;
    while (!valid && lat < 4) begin
      @(negedge clk);
      lat++;
    end
    if (e) bad_exp = va;
    chk("latency", lat, h ? 1 : 2);
    chk("tlbVAddr", tlbVAddr, va);
    chk("exc", exc, e);
    chk("excCode", excCode, c);
    chk("pAddr", pAddr, pa);
    chk("badVAddr", badVAddr, bad_exp);
    @(negedge clk);
    chk("valid_pulse", valid, 0);
    chk("pAddr_hold", pAddr, pa);
    if (!h && !e && va[31:30] != 2'b10) begin
      m_ok = 1; m_vpn = va[31:12]; m_asid = asid; m_pfn = tpa[31:12]; m_d = d;
    end
  endtask

  task automatic flush_pulse();
    @(negedge clk);
    tlbFlush = 1;
    @(negedge clk);
    tlbFlush = 0;
    m_ok = 0;
  endtask

  task automatic set_asid(input logic [7:0] a);
    @(negedge clk);
    if (a != asid) m_ok = 0;
    asid = a;
    @(negedge clk);
  endtask

  initial begin
    logic [31:0] va;
    repeat (2) @(negedge clk);
    chk("rst_valid", valid, 0);
    chk("rst_exc", exc, 0);
    chk("rst_pAddr", pAddr, 0);
    chk("rst_badVAddr", badVAddr, 0);
    chk("rst_tlbVAddr", tlbVAddr, 0);
    chk("rst_excCode", excCode, 0);
    res = 0;
    chk("ready_after_rst", ready, 1);
    do_req(32'h8000_1234, 0, 0, 0, 0, 0, 32'hDEAD_BEEF);
    chk("kseg0_pa", pAddr, 32'h0000_1234);
    do_req(32'hA000_0000, 1, 1, 1, 1, 1, 32'h1111_1111);
    chk("user_addr_err", excCode, 5);
    do_req(32'h0040_0010, 0, 0, 0, 1, 1, 32'h0123_4010);
    chk("refill_load", excCode, 2);
    do_req(32'h0040_0010, 1, 0, 1, 1, 0, 32'h0123_4010);
    chk("mod_store", excCode, 1);
    do_req(32'h0040_0010, 0, 0, 1, 0, 1, 32'h0123_4010);
    do_req(32'h0040_0010, 1, 0, 1, 0, 1, 32'h0123_4010);
    do_req(32'h0040_0010, 0, 0, 1, 1, 0, 32'h0123_4010);
    do_req(32'h0040_0FFC, 0, 0, 1, 1, 0, 32'h0123_4FFC);
    chk("utlb_hit_pa", pAddr, 32'h0123_4FFC);
    do_req(32'h0040_0010, 0, 0, 1, 1, 0, 32'h0123_4010);
    flush_pulse();
    do_req(32'h0040_0FFC, 0, 0, 1, 1, 0, 32'h0123_4FFC);
    set_asid(8'h05);
    do_req(32'h0040_0FFC, 0, 0, 1, 1, 0, 32'h0123_4FFC);
    do_req(32'h0040_0800, 1, 0, 1, 1, 0, 32'h0123_4800);
    // reset while the request sits in LOOKUP
    @(negedge clk);
    vAddr = 32'h0040_0010; isWrite = 0; userMode = 0; req = 1;
    @(negedge clk);
    req = 0; res = 1;
    #1 chk("rst_lookup_valid", valid, 0);
    @(negedge clk);
    res = 0; bad_exp = 0; m_ok = 0;
    chk("ready_release", ready, 1);
    chk("rst_tlbVAddr2", tlbVAddr, 0);
    chk("rst_pAddr2", pAddr, 0);
    repeat (3) begin
      @(negedge clk);
      chk("no_valid_after_rst", valid, 0);
    end
    do_req(32'h0040_0FFC, 0, 0, 1, 1, 1, 32'h0123_4FFC);
    for (int i = 0; i < 60; i++) begin
      case ($urandom_range(0, 4))
        0: va = 32'h8000_0000 | ($urandom & 32'h3FFF_FFFF);
        1: va = 32'hC000_0000 | $urandom;
        2: va = {m_vpn, 12'($urandom)};
        default: va = {20'($urandom_range(0, 3)) | 20'h00400, 12'($urandom)};
      endcase
      if ($urandom_range(0, 9) == 0) flush_pulse();
      if ($urandom_range(0, 9) == 0) set_asid(8'($urandom_range(0, 2)));
      do_req(va, 1'($urandom), $urandom_range(0, 4) == 0, $urandom_range(0, 5) != 0,
             $urandom_range(0, 5) != 0, 1'($urandom), $urandom);
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
